// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command responder.
// FSM state encoding, command byte values and the SPI byte width.
package spi_cmd_pkg;

    localparam int SPI_BYTE_W = 8;

    localparam logic [SPI_BYTE_W-1:0] CMD_DISPLAY_ON  = 8'hAF;
    localparam logic [SPI_BYTE_W-1:0] CMD_DISPLAY_OFF = 8'hAE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        WAIT_CS = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin into the i_Clk domain.
// Deliberately unreset so it keeps tracking the pin while the rest of the block is in reset.
module spi_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_cmd_responder.sv
// SPI mode-0 responder, oversampled in the i_Clk domain, with a one-byte TX holding register.
// Optional command decode of received bytes is built when CMD_DECODE_EN is defined.
module spi_cmd_responder
    import spi_cmd_pkg::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = 8'hFF
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_SPI_Clk,
    input  logic                  i_SPI_CS_n,
    input  logic                  i_SPI_MOSI,
    output logic                  o_SPI_MISO,
    output logic                  o_SPI_MISO_En,
    output logic [SPI_BYTE_W-1:0] o_RX_Byte,
    output logic                  o_RX_DV,
    input  logic [SPI_BYTE_W-1:0] i_TX_Byte,
    input  logic                  i_TX_DV,
    output logic                  o_TX_Ready,
    output logic                  o_Display_On,
    output spi_state_t            o_Fsm_State
);

    logic sck_s, cs_n_s, mosi_s, sck_prev;
    logic rise_edge, fall_edge;

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sck  (.clk(i_Clk), .d(i_SPI_Clk),  .q(sck_s));
    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_cs   (.clk(i_Clk), .d(i_SPI_CS_n), .q(cs_n_s));
    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(i_Clk), .d(i_SPI_MOSI), .q(mosi_s));

    always_ff @(posedge i_Clk) begin
        sck_prev <= sck_s;
    end

    assign rise_edge = sck_s & ~sck_prev;
    assign fall_edge = ~sck_s & sck_prev;

    spi_state_t state, state_next;
    logic       miso_en, frame_start, bit_rise, bit_fall;

    // A reset that lands mid-frame parks the FSM until CS is released.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= cs_n_s ? IDLE : WAIT_CS;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!cs_n_s) state_next = ACTIVE;
            ACTIVE:  if (cs_n_s)  state_next = IDLE;
            WAIT_CS: if (cs_n_s)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        miso_en     = 1'b0;
        frame_start = 1'b0;
        bit_rise    = 1'b0;
        bit_fall    = 1'b0;
        case (state)
            IDLE: frame_start = ~cs_n_s;
            ACTIVE: begin
                miso_en  = ~cs_n_s;
                bit_rise = ~cs_n_s & rise_edge;
                bit_fall = ~cs_n_s & fall_edge;
            end
            default: ;
        endcase
    end

    logic [SPI_BYTE_W-1:0] tx_shift, tx_hold, rx_full;
    logic [SPI_BYTE_W-2:0] rx_shift;
    logic [2:0]            bit_cnt;
    logic                  tx_ready, reload, byte_done;

    assign rx_full   = {rx_shift, mosi_s};
    assign byte_done = bit_rise && (bit_cnt == 3'd7);
    assign reload    = frame_start || (bit_fall && (bit_cnt == 3'd0));

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tx_shift  <= IDLE_BYTE;
            tx_hold   <= '0;
            tx_ready  <= 1'b1;
            rx_shift  <= '0;
            bit_cnt   <= 3'd0;
            o_RX_Byte <= '0;
            o_RX_DV   <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;
            if (frame_start) begin
                bit_cnt <= 3'd0;
            end
            if (bit_rise) begin
                rx_shift <= rx_full[SPI_BYTE_W-2:0];
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
                o_RX_Byte <= rx_full;
                o_RX_DV   <= 1'b1;
            end
            if (reload) begin
                tx_shift <= tx_ready ? IDLE_BYTE : tx_hold;
                tx_ready <= 1'b1;
            end else if (bit_fall) begin
                tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
            end
            // Gated on the pre-reload flag, so a write during a reload waits for the next boundary.
            if (i_TX_DV && tx_ready) begin
                tx_hold  <= i_TX_Byte;
                tx_ready <= 1'b0;
            end
        end
    end

`ifdef CMD_DECODE_EN
    logic display_on;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            display_on <= 1'b0;
        end else if (byte_done) begin
            if (rx_full == CMD_DISPLAY_ON) begin
                display_on <= 1'b1;
            end else if (rx_full == CMD_DISPLAY_OFF) begin
                display_on <= 1'b0;
            end
        end
    end

    assign o_Display_On = display_on;
`else
    assign o_Display_On = 1'b0;
`endif

    assign o_SPI_MISO    = tx_shift[SPI_BYTE_W-1];
    assign o_SPI_MISO_En = miso_en;
    assign o_TX_Ready    = tx_ready;
    assign o_Fsm_State   = state;

endmodule

// File: tb/tb_spi_cmd_responder.sv
// Bench for spi_cmd_responder: bit-banged SPI master at i_Clk/8, RX scoreboard on o_RX_DV.
// Set CMD_DECODE_EN to also exercise the display command decode.
module tb_spi_cmd_responder;
    import spi_cmd_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck, cs_n, mosi;
    logic       miso, miso_en;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic [7:0] tx_byte;
    logic       tx_dv;
    logic       tx_ready;
    logic       display_on;
    spi_state_t fsm_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];
    logic       exp_disp = 1'b0;

    spi_cmd_responder dut (
        .i_Clk(clk), .i_Rst(rst), .i_SPI_Clk(sck), .i_SPI_CS_n(cs_n), .i_SPI_MOSI(mosi),
        .o_SPI_MISO(miso), .o_SPI_MISO_En(miso_en), .o_RX_Byte(rx_byte), .o_RX_DV(rx_dv),
        .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv), .o_TX_Ready(tx_ready),
        .o_Display_On(display_on), .o_Fsm_State(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every o_RX_DV must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && rx_dv) begin
            check_eq("rx_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_neg(6);
    endtask

    task automatic cs_high();
        wait_neg(4);
        cs_n = 1'b1;
        wait_neg(8);
        check_eq("miso_en_off", 32'(miso_en), 32'd0);
    endtask

    task automatic send_bits(input logic [7:0] data, input int nbits, output logic [7:0] seen);
        seen = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = data[i];
            wait_neg(4);
            seen[i] = miso;
            sck = 1'b1;
            wait_neg(4);
            sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] data, input logic [7:0] miso_exp);
        logic [7:0] seen;
        exp_q.push_back(data);
        check_eq("miso_en_on", 32'(miso_en), 32'd1);
        send_bits(data, 8, seen);
        check_eq("miso_byte", 32'(seen), 32'(miso_exp));
    endtask

    task automatic write_tx(input logic [7:0] data);
        tx_byte = data;
        tx_dv = 1'b1;
        wait_neg(1);
        tx_dv = 1'b0;
        wait_neg(1);
    endtask

    task automatic drain();
        int budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            wait_neg(1);
            budget--;
        end
        check_eq("rx_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] junk;
        rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_byte = 8'h00; tx_dv = 1'b0;
        wait_neg(6);
        rst = 1'b0;
        wait_neg(1);
        check_eq("rst_miso", 32'(miso), 32'd1);
        check_eq("rst_miso_en", 32'(miso_en), 32'd0);
        check_eq("rst_rx_byte", 32'(rx_byte), 32'd0);
        check_eq("rst_rx_dv", 32'(rx_dv), 32'd0);
        check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
        check_eq("rst_display", 32'(display_on), 32'd0);
        check_eq("rst_state", 32'(fsm_state), 32'(IDLE));

        // Single byte, nothing queued: MISO sends the idle byte.
        cs_low();
        send_byte(8'hA5, 8'hFF);
        cs_high();
        drain();
        check_eq("rx_last_a5", 32'(rx_byte), 32'h0A5);

        // Preloaded response, two bytes in one frame.
        write_tx(8'h3C);
        check_eq("ready_after_wr", 32'(tx_ready), 32'd0);
        cs_low();
        check_eq("ready_at_csfall", 32'(tx_ready), 32'd1);
        send_byte(8'hAF, 8'h3C);
`ifdef CMD_DECODE_EN
        exp_disp = 1'b1;
`endif
        send_byte(8'h00, 8'hFF);
        cs_high();
        drain();
        check_eq("display_af", 32'(display_on), 32'(exp_disp));

        // Partial byte discarded, then a full byte.
        cs_low();
        send_bits(8'hF0, 5, junk);
        cs_high();
        cs_low();
        send_byte(8'h81, 8'hFF);
        cs_high();
        drain();
        check_eq("rx_last_81", 32'(rx_byte), 32'h081);

        // Second write while full is ignored.
        write_tx(8'h11);
        write_tx(8'h22);
        check_eq("ready_full", 32'(tx_ready), 32'd0);
        cs_low();
        send_byte(8'h55, 8'h11);
        cs_high();
        drain();
        check_eq("ready_emptied", 32'(tx_ready), 32'd1);

        // Reset mid-byte with CS low: outputs reset, frame ignored until CS cycles.
        cs_low();
        send_bits(8'hC3, 3, junk);
        write_tx(8'h77);
        rst = 1'b1;
        wait_neg(1);
        rst = 1'b0;
        wait_neg(1);
        check_eq("mid_rst_miso_en", 32'(miso_en), 32'd0);
        check_eq("mid_rst_rx_byte", 32'(rx_byte), 32'd0);
        check_eq("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
        check_eq("mid_rst_miso", 32'(miso), 32'd1);
        check_eq("mid_rst_display", 32'(display_on), 32'd0);
        check_eq("mid_rst_state", 32'(fsm_state), 32'(WAIT_CS));
        exp_disp = 1'b0;
        send_bits(8'hAF, 8, junk);
        send_bits(8'hAF, 8, junk);
        check_eq("wait_cs_no_en", 32'(miso_en), 32'd0);
        check_eq("wait_cs_display", 32'(display_on), 32'd0);
        cs_high();
        check_eq("after_wait_state", 32'(fsm_state), 32'(IDLE));
        cs_low();
        send_byte(8'h5A, 8'hFF);
        cs_high();
        drain();
        check_eq("rx_last_5a", 32'(rx_byte), 32'h05A);

        // Display command decode (stays 0 when decode is not built).
        cs_low();
        send_byte(8'hAF, 8'hFF);
        cs_high();
        drain();
`ifdef CMD_DECODE_EN
        exp_disp = 1'b1;
`endif
        check_eq("display_on_cmd", 32'(display_on), 32'(exp_disp));
        cs_low();
        send_byte(8'hAE, 8'hFF);
        cs_high();
        drain();
        exp_disp = 1'b0;
        check_eq("display_off_cmd", 32'(display_on), 32'(exp_disp));
        cs_low();
        send_byte(8'hAF, 8'hFF);
        send_byte(8'hA5, 8'hFF);
        cs_high();
        drain();
`ifdef CMD_DECODE_EN
        exp_disp = 1'b1;
`endif
        check_eq("display_other_cmd", 32'(display_on), 32'(exp_disp));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
